// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// One operation in flight at a time: IDLE (grant) -> EXEC (drive ALU,
// capture result) -> RESP (hold result until the owner accepts it).
//
// Handshake semantics (all ports): a transfer happens on a rising clock edge
// when valid and ready are both high in the cycle before that edge. Ready
// never depends on a transfer in the same cycle on another channel, and
// valid/payload are only sampled at the transfer edge.
module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic [DATA_WIDTH-1:0]    req0_a,
  input  logic [DATA_WIDTH-1:0]    req0_b,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  input  logic [DATA_WIDTH-1:0]    req1_a,
  input  logic [DATA_WIDTH-1:0]    req1_b,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  input  logic                     alu_zero,
  output logic                     rsp0_valid,
  input  logic                     rsp0_ready,
  output logic [DATA_WIDTH-1:0]    rsp0_result,
  output logic                     rsp0_zero,
  output logic                     rsp1_valid,
  input  logic                     rsp1_ready,
  output logic [DATA_WIDTH-1:0]    rsp1_result,
  output logic                     rsp1_zero,
  output logic                     busy,
  output logic [1:0]               o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic                     r_last_grant;
  logic                     r_owner;
  logic [OPCODE_LENGTH-1:0] r_op;
  logic [DATA_WIDTH-1:0]    r_a;
  logic [DATA_WIDTH-1:0]    r_b;
  logic [DATA_WIDTH-1:0]    r_result;
  logic                     r_zero;

  logic w_grant0;
  logic w_grant1;
  logic w_take;

  // Round-robin grant: a lone requester wins; on a tie the one that was not
  // granted last time wins. Grants are mutually exclusive by construction.
  assign w_grant0 = req0_valid & (~req1_valid | r_last_grant);
  assign w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
  assign w_take   = (r_state == S_IDLE) & (w_grant0 | w_grant1);

  // Next-state and all handshake / ALU-drive outputs; ALU inputs are forced
  // to zero outside EXEC so no stale operand reaches the shared datapath.
  always_comb begin
    w_next_state = r_state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    alu_op       = '0;
    alu_srca     = '0;
    alu_srcb     = '0;
    case (r_state)
      S_IDLE: begin
        req0_ready = w_grant0;
        req1_ready = w_grant1;
        if (w_grant0 | w_grant1) w_next_state = S_EXEC;
      end
      S_EXEC: begin
        alu_op       = r_op;
        alu_srca     = r_a;
        alu_srcb     = r_b;
        w_next_state = S_RESP;
      end
      S_RESP: begin
        rsp0_valid = ~r_owner;
        rsp1_valid = r_owner;
        if (r_owner ? rsp1_ready : rsp0_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Request capture on grant handshake; the reset value of last_grant makes
  // requester 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
    end else if (w_take) begin
      r_last_grant <= w_grant1;
      r_owner      <= w_grant1;
      r_op         <= w_grant1 ? req1_op : req0_op;
      r_a          <= w_grant1 ? req1_a  : req0_a;
      r_b          <= w_grant1 ? req1_b  : req0_b;
    end
  end

  // Response capture at the end of EXEC; held until the next EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_result <= alu_result;
      r_zero   <= alu_zero;
    end
  end

  // Both requesters see the same shared response register.
  assign rsp0_result = r_result;
  assign rsp0_zero   = r_zero;
  assign rsp1_result = r_result;
  assign rsp1_zero   = r_zero;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU attached to the ALU ports, per-owner
// expected queues filled at request handshake, and a negedge monitor that
// pops and compares whenever a response is consumed.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int OW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [OW-1:0] req0_op, req1_op, alu_op;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [DW-1:0] alu_srca, alu_srcb, alu_result;
  logic          alu_zero;
  logic          rsp0_valid, rsp0_ready, rsp0_zero;
  logic          rsp1_valid, rsp1_ready, rsp1_zero;
  logic [DW-1:0] rsp0_result, rsp1_result;
  logic          busy;
  logic [1:0]    dbg_state;

  alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .busy(busy), .o_dbg_state(dbg_state)
  );

  // ---------------- reference ALU ----------------
  // Returns {zero, result}. Branch ops (1001-1111) return result = taken and
  // zero = taken; other ops set zero when the result is 0.
  function automatic logic [DW:0] alu_ref(input logic [OW-1:0] op,
                                          input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    logic [DW-1:0] r;
    logic          t;
    r = '0;
    t = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0011: r = a << b[4:0];
      4'b0100: r = a ^ b;
      4'b0101: r = a >> b[4:0];
      4'b0110: r = a - b;
      4'b0111: r = $signed(a) >>> b[4:0];
      4'b1000: r = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1001: t = (a == b);
      4'b1010: t = (a != b);
      4'b1011: t = ($signed(a) < $signed(b));
      4'b1100: t = ($signed(a) >= $signed(b));
      4'b1101: t = (a < b);
      4'b1110: t = (a >= b);
      default: t = 1'b1;
    endcase
    if (op >= 4'b1001) return {t, {(DW-1){1'b0}}, t};
    return {(r == '0), r};
  endfunction

  assign {alu_zero, alu_result} = alu_ref(alu_op, alu_srca, alu_srcb);

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [DW:0] exp_q0[$];
  logic [DW:0] exp_q1[$];
  int          grant_log[$];

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: exclusivity, idle ALU drive, response hold, and in-order
  // comparison against the owner's expected queue.
  logic          hold0, hold1, pz0, pz1;
  logic [DW-1:0] pr0, pr1;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold0 = 1'b0;
      hold1 = 1'b0;
    end else begin
      check("rsp_exclusive", {rsp0_valid, rsp1_valid} == 2'b11, 0);
      if (!busy || rsp0_valid || rsp1_valid)
        check("alu_drive_idle", {alu_op, alu_srca, alu_srcb}, 0);
      if (hold0) check("rsp0_hold", {rsp0_valid, rsp0_zero, rsp0_result}, {1'b1, pz0, pr0});
      if (hold1) check("rsp1_hold", {rsp1_valid, rsp1_zero, rsp1_result}, {1'b1, pz1, pr1});
      if (rsp0_valid && rsp0_ready) begin
        if (exp_q0.size() == 0) fail_now("rsp0_unexpected");
        else check("rsp0_data", {rsp0_zero, rsp0_result}, exp_q0.pop_front());
      end
      if (rsp1_valid && rsp1_ready) begin
        if (exp_q1.size() == 0) fail_now("rsp1_unexpected");
        else check("rsp1_data", {rsp1_zero, rsp1_result}, exp_q1.pop_front());
      end
      hold0 = rsp0_valid && !rsp0_ready;
      hold1 = rsp1_valid && !rsp1_ready;
      pz0 = rsp0_zero;  pr0 = rsp0_result;
      pz1 = rsp1_zero;  pr1 = rsp1_result;
    end
  end

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; returns #1 after the handshake edge.
  task automatic drive0(input logic [OW-1:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b);
    int waited;
    waited = 0;
    req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    @(negedge clk);
    while (!req0_ready) begin
      waited++;
      if (waited > 200) begin
        fail_now("req0_timeout");
        req0_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    exp_q0.push_back(alu_ref(op, a, b));
    grant_log.push_back(0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
  endtask

  task automatic drive1(input logic [OW-1:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b);
    int waited;
    waited = 0;
    req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    @(negedge clk);
    while (!req1_ready) begin
      waited++;
      if (waited > 200) begin
        fail_now("req1_timeout");
        req1_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    exp_q1.push_back(alu_ref(op, a, b));
    grant_log.push_back(1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
  endtask

  task automatic rand_operands(output logic [OW-1:0] op, output logic [DW-1:0] a,
                               output logic [DW-1:0] b);
    op = OW'($urandom_range(0, 15));
    a  = $urandom;
    b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation did not finish");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic       seen;
    logic [1:0] st;
    logic       rand_done;
    rst_n = 1'b0;
    req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 0; rsp1_ready = 0;

    // Reset values, then combinational ready from a valid while in IDLE.
    repeat (2) @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_ready", {req0_ready, req1_ready}, 0);
    check("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    check("rst_alu", {alu_op, alu_srca, alu_srcb}, 0);
    check("rst_rsp_data", {rsp0_zero, rsp0_result}, 0);
    req0_valid = 1'b1; #1;
    check("rst_ready_with_valid", {req0_ready, req1_ready}, 2'b10);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Tie straight after reset, then sustained contention: 0,1,0,1...
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    grant_log.delete();
    fork
      for (int i = 0; i < 4; i++) drive0(4'b0010, DW'(i), 32'd10);
      for (int i = 0; i < 4; i++) drive1(4'b0110, 32'd100, DW'(i));
    join
    check("tie_grant_count", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      check($sformatf("tie_grant_%0d", i), grant_log[i], i % 2);
    repeat (6) @(posedge clk); #1;
    check("tie_drain", exp_q0.size() + exp_q1.size(), 0);

    // Reset in the middle of EXEC discards the operation.
    req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd5; req0_b = 32'd1;
    @(negedge clk);
    check("midrst_ready", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    check("midrst_in_exec", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_alu", {alu_op, alu_srca, alu_srcb}, 0);
    check("midrst_rsp0", rsp0_valid, 0);
    repeat (2) begin
      @(negedge clk);
      check("midrst_no_rsp", {rsp0_valid, rsp1_valid}, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midrst_idle_after", {busy, rsp0_valid, rsp1_valid}, 0);
    end
    @(posedge clk); #1;

    // Single ADD: cycle-exact latency.
    req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd7; req0_b = 32'hFFFF_FFFF;
    exp_q0.push_back({1'b0, 32'd6});
    @(negedge clk);
    check("add_ready_c0", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    check("add_alu_c1", {alu_op, alu_srca, alu_srcb}, {4'b0010, 32'd7, 32'hFFFF_FFFF});
    check("add_no_rsp_c1", rsp0_valid, 0);
    @(negedge clk);
    check("add_rsp_c2", {rsp0_valid, rsp0_zero, rsp0_result}, {1'b1, 1'b0, 32'd6});
    @(posedge clk); #1;

    // Branch taken on requester 1 (BLT -2 < 3).
    drive1(4'b1011, 32'hFFFF_FFFE, 32'd3);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("branch_rsp0_quiet", rsp0_valid, 0);
      if (rsp1_valid) begin
        check("branch_rsp", {rsp1_zero, rsp1_result}, {1'b1, 32'd1});
        seen = 1'b1;
      end
    end
    check("branch_seen", seen, 1);
    @(posedge clk); #1;

    // Backpressure on rsp0 with req1 waiting and a stray rsp1_ready.
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    drive0(4'b0100, 32'hF0, 32'hFF);
    req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 32'd3; req1_b = 32'd4;
    rsp1_ready = 1'b1;
    @(negedge clk);
    check("bp_exec_req1_ready", req1_ready, 0);
    st = 2'b00;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) st = dbg_state;
      else check("bp_state_stable", dbg_state, st);
      check("bp_rsp0", {rsp0_valid, rsp0_zero, rsp0_result}, {1'b1, 1'b0, 32'h0F});
      check("bp_req1_ready", req1_ready, 0);
    end
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    @(negedge clk);
    check("bp_release_req1_ready", req1_ready, 0);
    @(negedge clk);
    check("bp_req1_accept", req1_ready, 1);
    if (req1_ready) begin
      exp_q1.push_back({1'b0, 32'd7});
      grant_log.push_back(1);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    check("bp_drain", exp_q0.size() + exp_q1.size(), 0);

    // Randomized traffic with random response backpressure.
    rand_done = 1'b0;
    fork
      begin
        fork
          for (int i = 0; i < 30; i++) begin
            logic [OW-1:0] op;
            logic [DW-1:0] a, b;
            rand_operands(op, a, b);
            drive0(op, a, b);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
          end
          for (int i = 0; i < 30; i++) begin
            logic [OW-1:0] op;
            logic [DW-1:0] a, b;
            rand_operands(op, a, b);
            drive1(op, a, b);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
          end
        join
        rand_done = 1'b1;
      end
      while (!rand_done) begin
        @(posedge clk); #1;
        rsp0_ready = 1'($urandom_range(0, 1));
        rsp1_ready = 1'($urandom_range(0, 1));
      end
    join
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (exp_q0.size() == 0 && exp_q1.size() == 0 && !busy) break;
      @(posedge clk); #1;
    end
    check("rand_drain", exp_q0.size() + exp_q1.size(), 0);
    check("rand_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle combinational `alu` datapath between two requesters, for example the integer execute path and a branch/address helper. It does this through valid/ready handshakes and round-robin arbitration. The block registers one granted operation, drives the ALU for exactly one cycle, captures `ALUResult`/`Zero`, and holds the response until the owning requester accepts it. Only one operation is in flight at a time.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand/result width; must match the ALU instance.
- `OPCODE_LENGTH`, 4, ALU operation code width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req0_valid` / `req1_valid`  in  1  requester i presents an operation.
- `req0_ready` / `req1_ready`  out  1  operation accepted this cycle when valid & ready.
- `req0_op` / `req1_op`  in  OPCODE_LENGTH  ALU operation code, passed unmodified.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  DATA_WIDTH  operands.
- `alu_op`  out  OPCODE_LENGTH  to ALU `Operation`.
- `alu_srca`, `alu_srcb`  out  DATA_WIDTH  to ALU `SrcA`/`SrcB`.
- `alu_result`  in  DATA_WIDTH  from ALU `ALUResult`.
- `alu_zero`  in  1  from ALU `Zero`.
- `rsp0_valid` / `rsp1_valid`  out  1  response for requester i is available.
- `rsp0_ready` / `rsp1_ready`  in  1  requester i consumes the response.
- `rsp0_result` / `rsp1_result`  out  DATA_WIDTH  captured result.
- `rsp0_zero` / `rsp1_zero`  out  1  captured Zero flag.
- `busy`  out  1  high when state ≠ IDLE.

## Operation
- **States:** IDLE, EXEC, RESP. Encoding is free. Reset state is IDLE.
- **IDLE**
  - `reqX_ready` = 1 only for the granted requester. The other ready is 0.
  - If only one valid is high, that requester is granted.
  - If both are high, grant the requester ≠ `last_grant`.
  - On handshake: register op/a/b, set `owner` and `last_grant` to the granted index, go to EXEC.
  - If neither is valid, both readys are 0 and the block stays in IDLE.
- **EXEC**
  - `alu_op`/`alu_srca`/`alu_srcb` = registered values.
  - Capture `alu_result` and `alu_zero` into the response registers at the clock edge.
  - Go to RESP unconditionally.
- **RESP**
  - `rsp<owner>_valid` = 1. The other rsp_valid is 0.
  - Result and zero are held stable while valid and not ready.
  - On `rsp<owner>_ready`: go to IDLE.
  - `rsp_ready` of the non-owner is ignored.
- **ALU drive outside EXEC:** `alu_op`=0, `alu_srca`=0, `alu_srcb`=0. No operand leakage.
- **Request rules**
  - Requests are never accepted outside IDLE; both `reqX_ready` = 0 in EXEC and RESP.
  - Requesters must hold valid and payload stable until ready. The block does not rely on this beyond the handshake cycle.
- **No transformation:** no sign/width handling in the block. Op codes 0000–1111 are forwarded verbatim, and Zero semantics are the ALU's. This includes branch ops 1001–1111, where Zero means "branch taken".
- **`rspX_result`/`rspX_zero` outside valid:** hold the last captured value. Both outputs of each requester show the same shared register.
- **Reset values:** state=IDLE; `last_grant`=1, so req0 wins the first tie; op/operand/response registers = 0. Resulting outputs: all ready=0 unless a valid is already present, all rsp_valid=0, `busy`=0, ALU drive=0.
- **Reset mid-operation:** the in-flight operation is discarded, with no response. Outputs go to reset values asynchronously.

## Timing
- **Latency:** request handshake at edge N → EXEC during cycle N+1 → `rsp_valid` high from cycle N+2.
- **Response hold:** a response accepted in cycle M returns the block to IDLE at M+1. The next request handshake is possible in M+1.
- **Throughput:** minimum 3 cycles per operation, one outstanding.
- **Ready paths:** `reqX_ready` is combinational from state, both valids, and `last_grant`. There is no combinational path from `reqX_valid` to `rspX_*`.
- **Fairness:** continuous contention alternates grants 0,1,0,1…, so neither requester waits more than one foreign operation.

## Test plan
- **Reset:** assert `rst_n`=0 mid-EXEC with `req0_a`=5. Required: `rsp0_valid` stays 0, `busy`=0, `alu_*`=0 immediately; after release, IDLE.
- **Single ADD:** req0 op=0010, a=7, b=0xFFFFFFFF, `rsp0_ready`=1. Required: ready in cycle 0, `alu_op`=0010 in cycle 1, `rsp0_valid`=1 with result=6 and zero=0 in cycle 2.
- **Branch taken:** req1 op=1011 (BLT), a=0xFFFFFFFE, b=3. Required: `rsp1_result`=1, `rsp1_zero`=1, `rsp0_valid`=0 throughout.
- **Tie after reset, then sustained contention:** both valid, 4 ops each. Required: grant order 0,1,0,1,…; each response routed only to its owner.
- **Backpressure:** `rsp0_ready`=0 for 5 cycles after an XOR (op 0100, a=0xF0, b=0xFF). Required: result=0x0F held stable; `req1_ready`=0 throughout even with `req1_valid`=1; req1 is accepted the cycle after `rsp0_ready`=1.
- **Wrong-owner ready:** assert `rsp1_ready` while req0 owns RESP. Required: no state change; `rsp0_valid` stays 1.
